dmem_arbiter: RTL and testbench

- Two-port controller that shares the single data memory between the load/store stage (port 0) and the debug/DMA loader (port 1).
- Arbitrates between the two ports round-robin and latches the granted request.
- Sequences the memory's edge-triggered rd/wr strobes and owns the tristate data bus.
- Returns read data or an error to the requester with a one-cycle done pulse.

---
 rtl/dmem_arbiter_pkg.sv | 43 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
`timescale 1ns/1ps
// dmem_arbiter_pkg: shared widths, memory access-size codes, controller
// state encodings and the alignment helper used by the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int WIDTH              = 32;
  localparam int RD_TIMEOUT_DEFAULT = 4;

  localparam logic [1:0] DMEM_MODE_WORD    = 2'd0;
  localparam logic [1:0] DMEM_MODE_HALF    = 2'd1;
  localparam logic [1:0] DMEM_MODE_BYTE    = 2'd2;
  localparam logic [1:0] DMEM_MODE_ILLEGAL = 2'd3;

  localparam logic [2:0] DMA_ST_IDLE    = 3'd0;
  localparam logic [2:0] DMA_ST_SETUP   = 3'd1;
  localparam logic [2:0] DMA_ST_STROBE  = 3'd2;
  localparam logic [2:0] DMA_ST_HOLD    = 3'd3;
  localparam logic [2:0] DMA_ST_CAPTURE = 3'd4;
  localparam logic [2:0] DMA_ST_WAIT    = 3'd5;
  localparam logic [2:0] DMA_ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = DMA_ST_IDLE,
    ST_SETUP   = DMA_ST_SETUP,
    ST_STROBE  = DMA_ST_STROBE,
    ST_HOLD    = DMA_ST_HOLD,
    ST_CAPTURE = DMA_ST_CAPTURE,
    ST_WAIT    = DMA_ST_WAIT,
    ST_DONE    = DMA_ST_DONE
  } dma_state_t;

  // True when a word access is not 4-byte aligned or a halfword access is
  // not 2-byte aligned. Byte accesses are always aligned.
  function automatic logic misaligned(input logic [1:0] mode,
                                      input logic [1:0] add_lsb);
    logic bad;
    bad = 1'b0;
    if (mode == DMEM_MODE_WORD && add_lsb != 2'b00) bad = 1'b1;
    if (mode == DMEM_MODE_HALF && add_lsb[0])       bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
`timescale 1ns/1ps
// rr_arb2: two-way round-robin picker. 'last' is the port granted most
// recently; on a tie the other port wins so neither side can starve.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt_onehot,
  output logic       any
);

  // Lone requester wins outright; a tie goes to the port not served last.
  always_comb begin
    gnt_onehot = 2'b00;
    if (valid == 2'b11) begin
      gnt_onehot = last ? 2'b01 : 2'b10;
    end else begin
      gnt_onehot = valid;
    end
  end

  assign any = |valid;

endmodule

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares the single data memory between the load/store stage
// (port 0) and the debug/DMA loader (port 1). Grants round-robin, sequences
// the edge-triggered rd/wr strobes, owns the tristate data bus and returns
// read data or an error with a one-cycle done pulse.
// Build option: define DMEM_ALIGN_CHECK_EN to reject misaligned word and
// halfword accesses in IDLE without any memory access.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DW         = WIDTH,
  parameter int RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [DW-1:0] req_add0,
  input  logic [DW-1:0] req_add1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  input  logic [1:0]    req_mode0,
  input  logic [1:0]    req_mode1,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] mem_add,
  inout  wire  [DW-1:0] mem_data,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [1:0]    mem_mode,
  input  logic          mem_rd_st
);

  localparam int CW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  dma_state_t    state;
  dma_state_t    state_nxt;

  logic          gnt_q;
  logic          last_q;
  logic          we_q;
  logic          err_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] add_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [CW-1:0] wait_cnt;

  logic [1:0]    gnt_onehot;
  logic          any_req;
  logic          gnt_port;
  logic          sel_we;
  logic [1:0]    sel_mode;
  logic [DW-1:0] sel_add;
  logic [DW-1:0] sel_wdata;
  logic          reject;

  logic          rd_ok;
  logic          rd_capture;
  logic          rd_expire;
  logic          drive_bus;
  logic          addr_phase;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last       (last_q),
    .gnt_onehot (gnt_onehot),
    .any        (any_req)
  );

  assign gnt_port  = gnt_onehot[1] & ~gnt_onehot[0];
  assign sel_we    = gnt_port ? req_we[1]  : req_we[0];
  assign sel_mode  = gnt_port ? req_mode1  : req_mode0;
  assign sel_add   = gnt_port ? req_add1   : req_add0;
  assign sel_wdata = gnt_port ? req_wdata1 : req_wdata0;

  assign rd_ok = (mem_rd_st == 1'b1);

`ifdef DMEM_ALIGN_CHECK_EN
  assign reject = (sel_mode == DMEM_MODE_ILLEGAL) || misaligned(sel_mode, sel_add[1:0]);
`else
  assign reject = (sel_mode == DMEM_MODE_ILLEGAL);
`endif

  // Address and size are presented to memory only while a transfer is live.
  assign mem_add  = addr_phase ? add_q  : '0;
  assign mem_mode = addr_phase ? mode_q : 2'b00;
  assign mem_data = drive_bus ? wdata_q : {DW{1'bz}};
  assign rdata    = rdata_q;

  // State register; reset drops any in-flight transfer without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe/bus/done decode for the transfer sequence.
  always_comb begin
    state_nxt  = state;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    drive_bus  = 1'b0;
    addr_phase = 1'b0;
    done       = 2'b00;
    err        = 1'b0;
    rd_capture = 1'b0;
    rd_expire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = reject ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: begin
        addr_phase = 1'b1;
        drive_bus  = we_q;
        state_nxt  = ST_STROBE;
      end
      ST_STROBE: begin
        addr_phase = 1'b1;
        drive_bus  = we_q;
        mem_wr     = we_q;
        mem_rd     = ~we_q;
        state_nxt  = we_q ? ST_HOLD : ST_CAPTURE;
      end
      ST_HOLD: begin
        addr_phase = 1'b1;
        drive_bus  = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_CAPTURE: begin
        addr_phase = 1'b1;
        if (rd_ok) begin
          rd_capture = 1'b1;
          state_nxt  = ST_DONE;
        end else begin
          state_nxt  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        addr_phase = 1'b1;
        if (rd_ok) begin
          rd_capture = 1'b1;
          state_nxt  = ST_DONE;
        end else if (wait_cnt == CW'(RD_TIMEOUT - 1)) begin
          rd_expire  = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = gnt_q ? 2'b10 : 2'b01;
        err       = err_q;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch, round-robin pointer, read capture and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      mode_q   <= DMEM_MODE_WORD;
      add_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (state == ST_IDLE && any_req) begin
        gnt_q   <= gnt_port;
        last_q  <= gnt_port;
        we_q    <= sel_we;
        mode_q  <= sel_mode;
        add_q   <= sel_add;
        wdata_q <= sel_wdata;
        rdata_q <= '0;
        err_q   <= reject;
      end
      if (rd_capture) begin
        rdata_q <= mem_data;
      end
      if (rd_expire) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state == ST_CAPTURE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: randomized self-checking bench for dmem_arbiter with a
// byte-array memory model on the bus and a separate reference memory.
module tb_dmem_arbiter;

  localparam int RD_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [31:0] req_add0 = '0, req_add1 = '0;
  logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  req_mode0 = '0, req_mode1 = '0;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_add;
  wire  [31:0] mem_data;
  logic        mem_wr;
  logic        mem_rd;
  logic [1:0]  mem_mode;
  logic        mem_rd_st = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int model_last = 1;
  int txn_c0;
  bit stall = 1'b0;

  logic [7:0]  ref_mem [256];
  logic [7:0]  mem_arr [256];
  logic [31:0] mem_drv = '0;
  logic        mem_oe = 1'b0;

  int wr_cnt, rd_cnt, both_cnt, wr_cyc, rd_cyc, done_cnt;
  logic [31:0] st_add, st_data;
  logic [1:0]  st_mode;

  dmem_arbiter #(.DW(32), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_add0(req_add0), .req_add1(req_add1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_mode0(req_mode0), .req_mode1(req_mode1),
    .done(done), .err(err), .rdata(rdata), .mem_add(mem_add),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_mode(mem_mode), .mem_rd_st(mem_rd_st)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian gather of 4/2/1 bytes, zero-extended, from either array.
  function automatic logic [31:0] gather(input bit use_ref, input logic [31:0] add,
                                         input logic [1:0] mode);
    int n;
    logic [31:0] v;
    n = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 1 : 4;
    v = '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = use_ref ? ref_mem[8'(add + 32'(i))] : mem_arr[8'(add + 32'(i))];
    return v;
  endfunction

  task automatic scatter(input bit use_ref, input logic [31:0] add,
                         input logic [1:0] mode, input logic [31:0] data);
    int n;
    n = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 1 : 4;
    for (int i = 0; i < n; i++) begin
      if (use_ref) ref_mem[8'(add + 32'(i))] = data[8*i +: 8];
      else         mem_arr[8'(add + 32'(i))] = data[8*i +: 8];
    end
  endtask

  function automatic bit accepted(input logic [31:0] add, input logic [1:0] mode);
    if (mode == 2'd3) return 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (mode == 2'd0 && add[1:0] != 2'b00) return 1'b0;
    if (mode == 2'd1 && add[0]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic int exp_lat(input logic we, input logic [31:0] add, input logic [1:0] mode);
    if (!accepted(add, mode)) return 1;
    if (!we && stall) return 4 + RD_TIMEOUT;
    return 4;
  endfunction

  // Memory model: acts on rising strobes, drives read data until done.
  always @(posedge mem_wr) scatter(1'b0, mem_add, mem_mode, mem_data);

  always @(posedge mem_rd or posedge done[0] or posedge done[1] or posedge reset) begin
    if (reset || done != 2'b00) begin
      mem_oe    = 1'b0;
      mem_rd_st = 1'b0;
    end else if (mem_rd) begin
      mem_drv   = gather(1'b0, mem_add, mem_mode);
      mem_oe    = 1'b1;
      mem_rd_st = !stall;
    end
  end

  assign mem_data = mem_oe ? mem_drv : 32'bz;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wr) begin wr_cnt++; wr_cyc = cyc; st_add = mem_add; st_mode = mem_mode; st_data = mem_data; end
    if (mem_rd) begin rd_cnt++; rd_cyc = cyc; st_add = mem_add; st_mode = mem_mode; end
    if (mem_wr && mem_rd) both_cnt++;
    if (done != 2'b00) done_cnt++;
  end

  task automatic do_txn(input int port, input logic we, input logic [31:0] add,
                        input logic [31:0] wd, input logic [1:0] mode,
                        output int lat, output logic e, output logic [31:0] rd);
    @(posedge clk); #1;
    wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
    if (port == 0) begin req_add0 = add; req_wdata0 = wd; req_mode0 = mode; end
    else           begin req_add1 = add; req_wdata1 = wd; req_mode1 = mode; end
    req_we[port] = we;
    req_valid[port] = 1'b1;
    txn_c0 = cyc;
    lat = -1; e = 1'bx; rd = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[port]) begin lat = cyc - txn_c0; e = err; rd = rdata; break; end
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    model_last = port;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (done !== 2'b00) $display("[TB] FAIL reset_done: got %b expected 00", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
    n_checks++; if (mem_add !== 32'h0) $display("[TB] FAIL reset_mem_add: got %h expected 0", mem_add); else n_pass++;
    n_checks++; if (mem_mode !== 2'b00) $display("[TB] FAIL reset_mem_mode: got %b expected 00", mem_mode); else n_pass++;
    n_checks++; if ({mem_wr, mem_rd} !== 2'b00) $display("[TB] FAIL reset_strobes: got %b expected 00", {mem_wr, mem_rd}); else n_pass++;
    reset = 1'b0;
    model_last = 1;
  endtask

  task automatic test_write_read();
    int lat; logic e; logic [31:0] rd;
    do_txn(0, 1'b1, 32'h4, 32'hDEADBEEF, 2'd0, lat, e, rd);
    scatter(1'b1, 32'h4, 2'd0, 32'hDEADBEEF);
    n_checks++; if (lat !== 4) $display("[TB] FAIL wr_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("[TB] FAIL wr_err: got %b expected 0", e); else n_pass++;
    n_checks++; if (wr_cnt !== 1 || wr_cyc - txn_c0 !== 2) $display("[TB] FAIL wr_strobe: got count %0d at +%0d expected 1 at +2", wr_cnt, wr_cyc - txn_c0); else n_pass++;
    n_checks++; if (st_data !== 32'hDEADBEEF || st_add !== 32'h4) $display("[TB] FAIL wr_bus: got add %h data %h expected 4 deadbeef", st_add, st_data); else n_pass++;
    do_txn(0, 1'b0, 32'h4, 32'h0, 2'd0, lat, e, rd);
    n_checks++; if (lat !== 4) $display("[TB] FAIL rd_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL rd_data: got %h expected deadbeef", rd); else n_pass++;
    n_checks++; if (rd_cnt !== 1 || rd_cyc - txn_c0 !== 2 || wr_cnt !== 0) $display("[TB] FAIL rd_strobe: got rd %0d at +%0d wr %0d expected 1 at +2 wr 0", rd_cnt, rd_cyc - txn_c0, wr_cnt); else n_pass++;
  endtask

  task automatic test_byte_half();
    int lat; logic e; logic [31:0] rd; logic [31:0] exp;
    do_txn(1, 1'b1, 32'h3, 32'h000000AB, 2'd2, lat, e, rd);
    scatter(1'b1, 32'h3, 2'd2, 32'h000000AB);
    n_checks++; if (st_mode !== 2'd2 || wr_cnt !== 1) $display("[TB] FAIL byte_wr_mode: got %0d count %0d expected 2 count 1", st_mode, wr_cnt); else n_pass++;
    do_txn(0, 1'b0, 32'h2, 32'h0, 2'd1, lat, e, rd);
    exp = gather(1'b1, 32'h2, 2'd1);
    n_checks++; if (st_mode !== 2'd1) $display("[TB] FAIL half_rd_mode: got %0d expected 1", st_mode); else n_pass++;
    n_checks++; if (rd !== exp || rd[15:8] !== 8'hAB) $display("[TB] FAIL half_rd_data: got %h expected %h", rd, exp); else n_pass++;
  endtask

  task automatic test_illegal();
    int lat; logic e; logic [31:0] rd;
    do_txn(0, 1'b0, 32'h10, 32'h0, 2'd3, lat, e, rd);
    n_checks++; if (lat !== 1 || e !== 1'b1) $display("[TB] FAIL illegal_done: got lat %0d err %b expected 1 1", lat, e); else n_pass++;
    n_checks++; if (wr_cnt !== 0 || rd_cnt !== 0) $display("[TB] FAIL illegal_strobe: got wr %0d rd %0d expected 0 0", wr_cnt, rd_cnt); else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int port, lat, el, r;
      logic we, e, acc;
      logic [1:0] mode;
      logic [31:0] add, wd, rd, exp;
      port = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 7);
      mode = (r > 3) ? 2'($urandom_range(0, 2)) : 2'(r);
      add  = 32'($urandom_range(0, 63));
      wd   = $urandom;
      acc  = accepted(add, mode);
      el   = exp_lat(we, add, mode);
      exp  = gather(1'b1, add, mode);
      do_txn(port, we, add, wd, mode, lat, e, rd);
      n_checks++; if (lat !== el) $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, el); else n_pass++;
      n_checks++; if (e !== !acc) $display("[TB] FAIL rnd_err[%0d]: got %b expected %b", t, e, !acc); else n_pass++;
      n_checks++; if (wr_cnt !== int'(acc && we) || rd_cnt !== int'(acc && !we) || both_cnt !== 0)
        $display("[TB] FAIL rnd_strobes[%0d]: got wr %0d rd %0d both %0d expected %0d %0d 0", t, wr_cnt, rd_cnt, both_cnt, acc && we, acc && !we); else n_pass++;
      if (acc) begin
        n_checks++; if (st_add !== add || st_mode !== mode) $display("[TB] FAIL rnd_addr[%0d]: got %h/%0d expected %h/%0d", t, st_add, st_mode, add, mode); else n_pass++;
        if (we) begin
          n_checks++; if (st_data !== wd) $display("[TB] FAIL rnd_wdata[%0d]: got %h expected %h", t, st_data, wd); else n_pass++;
          scatter(1'b1, add, mode, wd);
        end else begin
          n_checks++; if (rd !== exp) $display("[TB] FAIL rnd_rdata[%0d]: got %h expected %h", t, rd, exp); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_port, got_port, prev, seen;
    logic [31:0] exp;
    req_add0 = 32'h0; req_mode0 = 2'd0; req_we[0] = 1'b0;
    req_add1 = 32'h8; req_mode1 = 2'd0; req_we[1] = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b11;
    prev = cyc; seen = 0;
    exp_port = 1 - model_last;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        got_port = done[1] ? 1 : 0;
        exp = gather(1'b1, got_port ? 32'h8 : 32'h0, 2'd0);
        n_checks++; if (got_port !== exp_port) $display("[TB] FAIL rr_port[%0d]: got %0d expected %0d", seen, got_port, exp_port); else n_pass++;
        n_checks++; if (cyc - prev !== (seen == 0 ? 4 : 5)) $display("[TB] FAIL rr_gap[%0d]: got %0d expected %0d", seen, cyc - prev, seen == 0 ? 4 : 5); else n_pass++;
        n_checks++; if (rdata !== exp || err !== 1'b0) $display("[TB] FAIL rr_rdata[%0d]: got %h err %b expected %h err 0", seen, rdata, err, exp); else n_pass++;
        model_last = got_port; exp_port = 1 - got_port; prev = cyc; seen++;
      end
    end
    n_checks++; if (seen !== 4) $display("[TB] FAIL rr_count: got %0d expected 4", seen); else n_pass++;
    @(posedge clk); #1;
    req_valid = 2'b00;
  endtask

  task automatic test_timeout();
    int lat; logic e; logic [31:0] rd;
    stall = 1'b1;
    do_txn(1, 1'b0, 32'h10, 32'h0, 2'd0, lat, e, rd);
    stall = 1'b0;
    n_checks++; if (lat !== 4 + RD_TIMEOUT) $display("[TB] FAIL timeout_latency: got %0d expected %0d", lat, 4 + RD_TIMEOUT); else n_pass++;
    n_checks++; if (e !== 1'b1 || rd !== 32'h0) $display("[TB] FAIL timeout_result: got err %b rdata %h expected 1 0", e, rd); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic e; logic [31:0] rd; logic [31:0] wd; bit hit;
    wd = $urandom; hit = 1'b0;
    req_add0 = 32'h20; req_wdata0 = wd; req_mode0 = 2'd0; req_we[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_wr) begin hit = 1'b1; break; end
    end
    n_checks++; if (hit !== 1'b1) $display("[TB] FAIL rst_mid_strobe: got %b expected 1", hit); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if ({mem_wr, mem_rd, done, err} !== 5'b0) $display("[TB] FAIL rst_mid_ctl: got %b expected 00000", {mem_wr, mem_rd, done, err}); else n_pass++;
    n_checks++; if (mem_add !== 32'h0 || mem_mode !== 2'b00 || rdata !== 32'h0) $display("[TB] FAIL rst_mid_data: got %h/%0d/%h expected 0/0/0", mem_add, mem_mode, rdata); else n_pass++;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    done_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (done_cnt !== 0) $display("[TB] FAIL rst_mid_nodone: got %0d expected 0", done_cnt); else n_pass++;
    if (hit) scatter(1'b1, 32'h20, 2'd0, wd);
    model_last = 1;
    do_txn(0, 1'b0, 32'h20, 32'h0, 2'd0, lat, e, rd);
    n_checks++; if (lat !== 4 || e !== 1'b0 || rd !== wd) $display("[TB] FAIL rst_mid_after: got lat %0d err %b rdata %h expected 4 0 %h", lat, e, rd, wd); else n_pass++;
  endtask

  task automatic test_align();
    int lat, el; logic e; logic [31:0] rd; logic [31:0] exp; bit acc;
    acc = accepted(32'h2, 2'd0);
    el  = exp_lat(1'b0, 32'h2, 2'd0);
    exp = gather(1'b1, 32'h2, 2'd0);
    do_txn(0, 1'b0, 32'h2, 32'h0, 2'd0, lat, e, rd);
    n_checks++; if (lat !== el || e !== !acc) $display("[TB] FAIL align_word: got lat %0d err %b expected %0d %b", lat, e, el, !acc); else n_pass++;
    n_checks++; if (rd_cnt !== int'(acc)) $display("[TB] FAIL align_word_strobe: got %0d expected %0d", rd_cnt, acc); else n_pass++;
    if (acc) begin
      n_checks++; if (rd !== exp) $display("[TB] FAIL align_word_data: got %h expected %h", rd, exp); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      ref_mem[i] = b;
      mem_arr[i] = b;
    end
    test_reset();
    test_write_read();
    test_byte_half();
    test_illegal();
    test_round_robin();
    test_timeout();
    test_random();
    test_align();
    test_reset_mid();
    test_round_robin();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
